// File: rtl/soc_system_video_pll_pkg.sv
// Shared types and defaults for the video PLL lock monitor.
// Holds the FSM state enum, default timings and the counter-width helper.
package soc_system_video_pll_pkg;

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } state_e;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 65536;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_CNT_W         = 8;

    // Width of the phase counter: wide enough for the longest phase.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        int w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/soc_system_video_pll_lock_sync.sv
// Two-flop synchronizer, asynchronously reset to 0.
// Ports: clk, rst (async, active-high), d (async input), q (synchronized).
module soc_system_video_pll_lock_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    (* ASYNC_REG = "TRUE", altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED" *)
    logic [WIDTH-1:0] meta_q;
    (* ASYNC_REG = "TRUE", altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED" *)
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/soc_system_video_pll_lock_monitor.sv
// Video PLL reset sequencer and lock qualifier on the 50 MHz refclk.
// Ports: refclk, rst (async high), pll_locked (async), relock_req;
// outputs pll_rst, video_rst, lock_ok, loss_count, timeout_count.
module soc_system_video_pll_lock_monitor
    import soc_system_video_pll_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             relock_req,
    output logic             pll_rst,
    output logic             video_rst,
    output logic             lock_ok,
    output logic [CNT_W-1:0] loss_count,
    output logic [CNT_W-1:0] timeout_count
);

    localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] ST_LAST  = CW'(STABLE_CYCLES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic             locked_s;
    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic [CNT_W-1:0] timeout_q, timeout_d;
    logic             pll_rst_q, pll_rst_d;
    logic             video_rst_q, video_rst_d;
    logic             lock_ok_q, lock_ok_d;

    soc_system_video_pll_lock_sync #(
        .WIDTH(1)
    ) u_sync (
        .clk(refclk),
        .rst(rst),
        .d  (pll_locked),
        .q  (locked_s)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        loss_d    = loss_q;
        timeout_d = timeout_q;
        if (relock_req) begin
            state_d = S_PLL_RST;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_PLL_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = S_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TO_LAST) begin
                        state_d   = S_PLL_RST;
                        cnt_d     = '0;
                        timeout_d = sat_inc(timeout_q);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_STABLE: begin
                    // A dropout here is a glitch: requalify from scratch.
                    if (!locked_s) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == ST_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        state_d = S_PLL_RST;
                        cnt_d   = '0;
                        loss_d  = sat_inc(loss_q);
                    end
                end
                default: begin
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                end
            endcase
        end
        // Decoded from next state so outputs move with the state.
        pll_rst_d   = (state_d == S_PLL_RST);
        video_rst_d = (state_d != S_RUN);
        lock_ok_d   = (state_d == S_RUN);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= S_PLL_RST;
            cnt_q       <= '0;
            loss_q      <= '0;
            timeout_q   <= '0;
            pll_rst_q   <= 1'b1;
            video_rst_q <= 1'b1;
            lock_ok_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            loss_q      <= loss_d;
            timeout_q   <= timeout_d;
            pll_rst_q   <= pll_rst_d;
            video_rst_q <= video_rst_d;
            lock_ok_q   <= lock_ok_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign video_rst     = video_rst_q;
    assign lock_ok       = lock_ok_q;
    assign loss_count    = loss_q;
    assign timeout_count = timeout_q;

endmodule

// File: tb/tb_soc_system_video_pll_lock_monitor.sv
// Bench for the video PLL lock monitor: directed scenarios plus
// randomized lock/relock traffic against a phase-timer reference model.
module tb_soc_system_video_pll_lock_monitor;

    localparam int RC = 4;
    localparam int LT = 32;
    localparam int SC = 8;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_QUAL = 2;
    localparam int P_RUN  = 3;

    logic refclk = 1'b0;
    logic rst = 1'b1;
    logic pll_locked = 1'b0;
    logic relock_req = 1'b0;
    logic pll_rst;
    logic video_rst;
    logic lock_ok;
    logic [CW-1:0] loss_count;
    logic [CW-1:0] timeout_count;

    int n_tests = 0;
    int n_fail = 0;

    // Reference model: phase, time spent in phase, 2-deep lock pipe.
    int m_phase;
    int m_elapsed;
    bit m_s1;
    bit m_s2;
    int m_loss;
    int m_to;

    soc_system_video_pll_lock_monitor #(
        .RST_CYCLES(RC),
        .LOCK_TIMEOUT(LT),
        .STABLE_CYCLES(SC),
        .CNT_W(CW)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .pll_locked(pll_locked),
        .relock_req(relock_req),
        .pll_rst(pll_rst),
        .video_rst(video_rst),
        .lock_ok(lock_ok),
        .loss_count(loss_count),
        .timeout_count(timeout_count)
    );

    always #10 refclk = ~refclk;

    function automatic void model_reset();
        m_phase = P_RST;
        m_elapsed = 0;
        m_s1 = 1'b0;
        m_s2 = 1'b0;
        m_loss = 0;
        m_to = 0;
    endfunction

    function automatic void enter(input int p);
        m_phase = p;
        m_elapsed = 0;
    endfunction

    // One refclk edge: a phase ends once it has lasted its full length.
    function automatic void model_edge(input bit lk, input bit rq);
        bit seen;
        seen = m_s2;
        m_s2 = m_s1;
        m_s1 = lk;
        if (rq) begin
            enter(P_RST);
        end else if (m_phase == P_RST) begin
            if (m_elapsed + 1 == RC) enter(P_WAIT);
            else m_elapsed++;
        end else if (m_phase == P_WAIT) begin
            if (seen) begin
                enter(P_QUAL);
            end else if (m_elapsed + 1 == LT) begin
                enter(P_RST);
                if (m_to < SAT) m_to++;
            end else begin
                m_elapsed++;
            end
        end else if (m_phase == P_QUAL) begin
            if (!seen) enter(P_WAIT);
            else if (m_elapsed + 1 == SC) enter(P_RUN);
            else m_elapsed++;
        end else begin
            if (!seen) begin
                enter(P_RST);
                if (m_loss < SAT) m_loss++;
            end
        end
    endfunction

    task automatic tick();
        @(posedge refclk);
        model_edge(pll_locked, relock_req);
        @(negedge refclk);
    endtask

    task automatic do_reset();
        @(negedge refclk);
        rst = 1'b1;
        relock_req = 1'b0;
        model_reset();
        @(negedge refclk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        @(negedge refclk);
        n_tests++;
        if (pll_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pll_rst: got %b want 1", pll_rst);
        end
        n_tests++;
        if (video_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_video_rst: got %b want 1", video_rst);
        end
        n_tests++;
        if (lock_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_lock_ok: got %b want 0", lock_ok);
        end
        n_tests++;
        if (loss_count !== 4'd0 || timeout_count !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_counts: got %0d/%0d want 0/0",
                     loss_count, timeout_count);
        end
    endtask

    task automatic test_powerup_lock();
        int hi;
        int e;
        pll_locked = 1'b0;
        do_reset();
        hi = 0;
        while (pll_rst === 1'b1 && hi < 100) begin
            hi++;
            tick();
        end
        n_tests++;
        if (hi != RC) begin
            n_fail++;
            $display("FAIL pwr_pll_rst_len: got %0d want %0d", hi, RC);
        end
        repeat ((hi < 10) ? 10 - hi : 0) tick();
        pll_locked = 1'b1;
        e = 0;
        while (video_rst === 1'b1 && e < 200) begin
            tick();
            e++;
        end
        n_tests++;
        if (e != SC + 3) begin
            n_fail++;
            $display("FAIL pwr_release_lat: got %0d want %0d", e, SC + 3);
        end
        n_tests++;
        if (lock_ok !== 1'b1 || loss_count !== 4'd0 || timeout_count !== 4'd0) begin
            n_fail++;
            $display("FAIL pwr_run_state: got ok=%b loss=%0d to=%0d want 1/0/0",
                     lock_ok, loss_count, timeout_count);
        end
    endtask

    task automatic test_no_lock();
        int hi;
        int lo;
        int exp_to;
        bit vr_low;
        vr_low = 1'b0;
        pll_locked = 1'b0;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            hi = 0;
            while (pll_rst === 1'b1 && hi < 100) begin
                if (video_rst !== 1'b1) vr_low = 1'b1;
                hi++;
                tick();
            end
            lo = 0;
            while (pll_rst === 1'b0 && lo < 100) begin
                if (video_rst !== 1'b1) vr_low = 1'b1;
                lo++;
                tick();
            end
            exp_to = (k + 1 > SAT) ? SAT : k + 1;
            n_tests++;
            if (hi != RC) begin
                n_fail++;
                $display("FAIL nolock_pulse[%0d]: got %0d want %0d", k, hi, RC);
            end
            n_tests++;
            if (lo != LT) begin
                n_fail++;
                $display("FAIL nolock_wait[%0d]: got %0d want %0d", k, lo, LT);
            end
            n_tests++;
            if (int'(timeout_count) != exp_to) begin
                n_fail++;
                $display("FAIL nolock_to[%0d]: got %0d want %0d",
                         k, timeout_count, exp_to);
            end
        end
        n_tests++;
        if (vr_low) begin
            n_fail++;
            $display("FAIL nolock_video_rst: got 0 want 1");
        end
    endtask

    task automatic test_glitch();
        int e;
        int g;
        bit saw_rst;
        saw_rst = 1'b0;
        pll_locked = 1'b0;
        do_reset();
        repeat (RC) tick();
        pll_locked = 1'b1;
        g = 0;
        while (!(m_phase == P_QUAL && m_elapsed == 3) && g < 100) begin
            tick();
            g++;
        end
        // Low for one cycle; seen by the qualifier two edges later (cnt=5).
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        e = 0;
        while (video_rst === 1'b1 && e < 200) begin
            if (pll_rst === 1'b1) saw_rst = 1'b1;
            tick();
            e++;
        end
        n_tests++;
        if (e != SC + 3) begin
            n_fail++;
            $display("FAIL glitch_release_lat: got %0d want %0d", e, SC + 3);
        end
        n_tests++;
        if (saw_rst || pll_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_pll_rst: got pulse want none");
        end
        n_tests++;
        if (loss_count !== 4'd0) begin
            n_fail++;
            $display("FAIL glitch_loss: got %0d want 0", loss_count);
        end
    endtask

    task automatic test_loss_in_run();
        int e;
        pll_locked = 1'b0;
        e = 0;
        while (video_rst === 1'b0 && e < 50) begin
            tick();
            e++;
        end
        n_tests++;
        if (e != 3 || pll_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL loss_latency: got %0d pll_rst=%b want 3 1", e, pll_rst);
        end
        n_tests++;
        if (loss_count !== 4'd1) begin
            n_fail++;
            $display("FAIL loss_count: got %0d want 1", loss_count);
        end
        pll_locked = 1'b1;
        e = 0;
        while (video_rst === 1'b1 && e < 200) begin
            tick();
            e++;
        end
        // Sync settles during the PLL reset; one edge to start qualifying.
        n_tests++;
        if (e != RC + 1 + SC || lock_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL loss_relock_lat: got %0d ok=%b want %0d 1",
                     e, lock_ok, RC + 1 + SC);
        end
    endtask

    task automatic test_relock();
        int hi;
        pll_locked = 1'b0;
        tick();
        tick();
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        n_tests++;
        if (pll_rst !== 1'b1 || video_rst !== 1'b1 || lock_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL relock_outputs: got %b%b%b want 110",
                     pll_rst, video_rst, lock_ok);
        end
        n_tests++;
        if (loss_count !== 4'd1) begin
            n_fail++;
            $display("FAIL relock_loss: got %0d want 1", loss_count);
        end
        pll_locked = 1'b1;
        hi = 0;
        while (pll_rst === 1'b1 && hi < 100) begin
            hi++;
            tick();
        end
        n_tests++;
        if (hi != RC) begin
            n_fail++;
            $display("FAIL relock_pulse: got %0d want %0d", hi, RC);
        end
    endtask

    task automatic test_async_reset();
        int g;
        int hi;
        int e;
        g = 0;
        while (!(m_phase == P_QUAL && m_elapsed == 4) && g < 100) begin
            tick();
            g++;
        end
        #5;
        rst = 1'b1;
        #1;
        n_tests++;
        if (pll_rst !== 1'b1 || video_rst !== 1'b1 || lock_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_outputs: got %b%b%b want 110",
                     pll_rst, video_rst, lock_ok);
        end
        n_tests++;
        if (loss_count !== 4'd0 || timeout_count !== 4'd0) begin
            n_fail++;
            $display("FAIL arst_counts: got %0d/%0d want 0/0",
                     loss_count, timeout_count);
        end
        model_reset();
        @(negedge refclk);
        rst = 1'b0;
        hi = 0;
        while (pll_rst === 1'b1 && hi < 100) begin
            hi++;
            tick();
        end
        e = hi;
        while (video_rst === 1'b1 && e < 200) begin
            tick();
            e++;
        end
        n_tests++;
        if (hi != RC || e != RC + 1 + SC) begin
            n_fail++;
            $display("FAIL arst_restart: got %0d/%0d want %0d/%0d",
                     hi, e, RC, RC + 1 + SC);
        end
    endtask

    task automatic test_random();
        int run_left;
        logic [10:0] got;
        logic [10:0] exp;
        run_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                #4;
                rst = 1'b1;
                model_reset();
                #1;
                got = {pll_rst, video_rst, lock_ok, loss_count, timeout_count};
                n_tests++;
                if (got !== 11'b110_0000_0000) begin
                    n_fail++;
                    $display("FAIL rnd_arst[%0d]: got %b want 11000000000", c, got);
                end
                @(negedge refclk);
                rst = 1'b0;
            end
            if (run_left == 0) begin
                pll_locked = ~pll_locked;
                run_left = pll_locked ? $urandom_range(1, 80) : $urandom_range(1, 45);
            end
            run_left--;
            relock_req = ($urandom_range(0, 59) == 0);
            tick();
            exp = {m_phase == P_RST, m_phase != P_RUN, m_phase == P_RUN,
                   m_loss[CW-1:0], m_to[CW-1:0]};
            got = {pll_rst, video_rst, lock_ok, loss_count, timeout_count};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL rnd_cycle[%0d]: got %b want %b", c, got, exp);
            end
        end
        relock_req = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_powerup_lock();
        test_no_lock();
        test_glitch();
        test_loss_in_run();
        test_relock();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
